// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: one request per handshake, executed over an AXI4-Lite master, load data extended.
// Zero-wait bus gives out_valid 3 cycles after accept (1 for misaligned/no-op); out_valid holds until out_ready.
module ysyx_23060203_lsu (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [2:0]  in_func,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, DONE} state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  func_q;
    logic        err_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic [4:0]  in_sh;
    logic        mis_d;
    logic [3:0]  strb_d;
    logic [31:0] rsh;
    logic [31:0] ld_d;
    logic        aw_ok;
    logic        w_ok;

    assign in_sh = {in_addr[1:0], 3'b000};

    // func[1:0] selects the access size; 11 (undefined) falls into the word case
    always_comb begin
        mis_d  = 1'b0;
        strb_d = 4'hF;
        case (in_func[1:0])
            2'b00: begin
                mis_d  = 1'b0;
                strb_d = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                mis_d  = in_addr[0];
                strb_d = 4'b0011 << in_addr[1:0];
            end
            default: begin
                mis_d  = |in_addr[1:0];
                strb_d = 4'hF;
            end
        endcase
    end

    assign rsh = rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_d = rsh;
        case (func_q)
            3'b000:  ld_d = {{24{rsh[7]}}, rsh[7:0]};
            3'b100:  ld_d = {24'd0, rsh[7:0]};
            3'b001:  ld_d = {{16{rsh[15]}}, rsh[15:0]};
            3'b101:  ld_d = {16'd0, rsh[15:0]};
            default: ld_d = rsh;
        endcase
    end

    // A channel counts as done if it completed earlier or completes this cycle
    assign aw_ok = aw_done_q | awready;
    assign w_ok  = w_done_q | wready;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign arvalid   = (state_q == RADDR);
    assign rready    = (state_q == RDATA);
    assign awvalid   = (state_q == WRITE) && !aw_done_q;
    assign wvalid    = (state_q == WRITE) && !w_done_q;
    assign bready    = (state_q == WRESP);
    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            func_q    <= 3'd0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        addr_q    <= in_addr;
                        func_q    <= in_func;
                        wdata_q   <= in_wdata << in_sh;
                        wstrb_q   <= strb_d;
                        rdata_q   <= 32'd0;
                        err_q     <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (mis_d) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (in_wen) begin
                            state_q <= WRITE;
                        end else if (in_ren) begin
                            state_q <= RADDR;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                RADDR: begin
                    if (arready) state_q <= RDATA;
                end
                RDATA: begin
                    if (rvalid) begin
                        rdata_q <= ld_d;
                        err_q   <= (rresp != 2'b00);
                        state_q <= DONE;
                    end
                end
                WRITE: begin
                    if (awready) aw_done_q <= 1'b1;
                    if (wready)  w_done_q  <= 1'b1;
                    if (aw_ok && w_ok) state_q <= WRESP;
                end
                WRESP: begin
                    if (bvalid) begin
                        err_q   <= (bresp != 2'b00);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Scoreboard bench for the LSU: expected {rdata, err} pushed on request, popped on response.
module tb_ysyx_23060203_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_ren = 1'b0;
    logic        in_wen = 1'b0;
    logic [2:0]  in_func = 3'd0;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_rdata;
    logic        out_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'd0;
    logic        bvalid = 1'b0;
    logic        bready;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] e;

    always #5 clock = ~clock;

    ysyx_23060203_lsu dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_func(in_func), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    // Drive one request for one cycle; returns at the negedge after acceptance
    task automatic send(input logic r, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1; in_ren = r; in_wen = w; in_func = f; in_addr = a; in_wdata = d;
        @(negedge clock);
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({in_ready, out_valid, arvalid, rready, awvalid, wvalid, bready} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 1000000",
                     {in_ready, out_valid, arvalid, rready, awvalid, wvalid, bready});
        end
        checks++;
        if (out_rdata !== 32'd0 || out_err !== 1'b0 || araddr !== 32'd0 || wstrb !== 4'd0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h err=%b araddr=%h wstrb=%b want zeros",
                     out_rdata, out_err, araddr, wstrb);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_lb();
        arready = 1'b1;
        exp_q.push_back({32'hFFFFFF80, 1'b0});
        send(1'b1, 1'b0, 3'b000, 32'h80000003, 32'd0);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h80000003) begin
            errors++;
            $display("FAIL lb_ar got arvalid=%b araddr=%h want 1/80000003", arvalid, araddr);
        end
        @(negedge clock);
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1 || arvalid !== 1'b0) begin
            errors++;
            $display("FAIL lb_rready got rready=%b arvalid=%b want 1/0", rready, arvalid);
        end
        rvalid = 1'b1; rdata = 32'h80123456; rresp = 2'b00;
        @(negedge clock);
        rvalid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL lb_latency got out_valid=%b want 1 at T+3", out_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if ({out_rdata, out_err} !== e) begin
            errors++;
            $display("FAIL lb_data got %h/%b want %h/%b", out_rdata, out_err, e[32:1], e[0]);
        end
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_lhu_delay();
        arready = 1'b0;
        exp_q.push_back({32'h0000BEEF, 1'b0});
        send(1'b1, 1'b0, 3'b101, 32'h80000002, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (arvalid !== 1'b1 || araddr !== 32'h80000002) begin
                errors++;
                $display("FAIL lhu_ar_hold cycle %0d got arvalid=%b araddr=%h want 1/80000002",
                         i, arvalid, araddr);
            end
            if (i == 2) arready = 1'b1;
            @(negedge clock);
        end
        arready = 1'b0;
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b1) begin
            errors++;
            $display("FAIL lhu_rphase got arvalid=%b rready=%b want 0/1", arvalid, rready);
        end
        rvalid = 1'b1; rdata = 32'hBEEF1234; rresp = 2'b00;
        @(negedge clock);
        rvalid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {out_rdata, out_err} !== e) begin
            errors++;
            $display("FAIL lhu_data got v=%b %h/%b want 1 %h/%b",
                     out_valid, out_rdata, out_err, e[32:1], e[0]);
        end
        @(negedge clock);
    endtask

    task automatic test_sb();
        awready = 1'b0; wready = 1'b1;
        exp_q.push_back({32'd0, 1'b0});
        send(1'b0, 1'b1, 3'b000, 32'h80000002, 32'h000000AB);
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h80000002) begin
            errors++;
            $display("FAIL sb_valid got aw=%b w=%b awaddr=%h want 1/1/80000002",
                     awvalid, wvalid, awaddr);
        end
        checks++;
        if (wdata !== 32'h00AB0000 || wstrb !== 4'b0100) begin
            errors++;
            $display("FAIL sb_lane got wdata=%h wstrb=%b want 00ab0000/0100", wdata, wstrb);
        end
        @(negedge clock);
        wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (awvalid !== 1'b1 || wvalid !== 1'b0 || bready !== 1'b0 || awaddr !== 32'h80000002) begin
                errors++;
                $display("FAIL sb_aw_wait cycle %0d got aw=%b w=%b b=%b want 1/0/0",
                         i, awvalid, wvalid, bready);
            end
            if (i == 2) awready = 1'b1;
            @(negedge clock);
        end
        awready = 1'b0;
        checks++;
        if (awvalid !== 1'b0 || bready !== 1'b1) begin
            errors++;
            $display("FAIL sb_bready got aw=%b bready=%b want 0/1", awvalid, bready);
        end
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clock);
        bvalid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {out_rdata, out_err} !== e) begin
            errors++;
            $display("FAIL sb_resp got v=%b %h/%b want 1 %h/%b",
                     out_valid, out_rdata, out_err, e[32:1], e[0]);
        end
        @(negedge clock);
    endtask

    task automatic test_misaligned();
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        exp_q.push_back({32'd0, 1'b1});
        send(1'b1, 1'b0, 3'b010, 32'h80000002, 32'd0);
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || arvalid !== 1'b0 || {out_rdata, out_err} !== e) begin
            errors++;
            $display("FAIL mis_lw got v=%b ar=%b %h/%b want 1 0 %h/%b",
                     out_valid, arvalid, out_rdata, out_err, e[32:1], e[0]);
        end
        @(negedge clock);
        exp_q.push_back({32'd0, 1'b1});
        send(1'b0, 1'b1, 3'b001, 32'h80000001, 32'h5555);
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0 || {out_rdata, out_err} !== e) begin
            errors++;
            $display("FAIL mis_sh got v=%b aw=%b w=%b %h/%b want 1 0 0 %h/%b",
                     out_valid, awvalid, wvalid, out_rdata, out_err, e[32:1], e[0]);
        end
        @(negedge clock);
        exp_q.push_back({32'd0, 1'b0});
        send(1'b0, 1'b0, 3'b010, 32'h80000008, 32'd0);
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || arvalid !== 1'b0 || {out_rdata, out_err} !== e) begin
            errors++;
            $display("FAIL noop got v=%b ar=%b %h/%b want 1 0 %h/%b",
                     out_valid, arvalid, out_rdata, out_err, e[32:1], e[0]);
        end
        @(negedge clock);
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
    endtask

    task automatic test_sw_err();
        awready = 1'b1; wready = 1'b1;
        exp_q.push_back({32'd0, 1'b1});
        send(1'b0, 1'b1, 3'b010, 32'h80000010, 32'h12345678);
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || wdata !== 32'h12345678 || wstrb !== 4'hF) begin
            errors++;
            $display("FAIL sw_write got aw=%b w=%b wdata=%h wstrb=%b want 1/1/12345678/1111",
                     awvalid, wvalid, wdata, wstrb);
        end
        @(negedge clock);
        awready = 1'b0; wready = 1'b0;
        checks++;
        if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            errors++;
            $display("FAIL sw_bready got b=%b aw=%b w=%b want 1/0/0", bready, awvalid, wvalid);
        end
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clock);
        bvalid = 1'b0; bresp = 2'b00;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {out_rdata, out_err} !== e) begin
            errors++;
            $display("FAIL sw_err got v=%b %h/%b want 1 %h/%b",
                     out_valid, out_rdata, out_err, e[32:1], e[0]);
        end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        arready = 1'b1; out_ready = 1'b0;
        exp_q.push_back({32'hCAFEF00D, 1'b0});
        send(1'b1, 1'b0, 3'b010, 32'h80000004, 32'd0);
        @(negedge clock);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b00;
        @(negedge clock);
        rvalid = 1'b0; rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_rdata !== 32'hCAFEF00D || out_err !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b rdata=%h err=%b in_ready=%b want 1/cafef00d/0/0",
                         i, out_valid, out_rdata, out_err, in_ready);
            end
            @(negedge clock);
        end
        out_ready = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_rdata, out_err} !== e) begin
            errors++;
            $display("FAIL bp_handshake got v=%b in_ready=%b %h/%b want 1 0 %h/%b",
                     out_valid, in_ready, out_rdata, out_err, e[32:1], e[0]);
        end
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got in_ready=%b v=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  funcs[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f;
        logic [1:0]  off;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        logic        st;
        int          n;
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            f = funcs[$urandom_range(0, 4)];
            if (f[1:0] == 2'b00)      off = 2'($urandom_range(0, 3));
            else if (f[1:0] == 2'b01) off = {1'($urandom_range(0, 1)), 1'b0};
            else                      off = 2'd0;
            a  = ($urandom & 32'hFFFFFFFC) | {30'd0, off};
            d  = $urandom;
            st = 1'($urandom_range(0, 1));
            if (st && f[2]) f = {1'b0, f[1:0]};
            if (st) exp_q.push_back({32'd0, 1'b0});
            else    exp_q.push_back({model_load(f, off, d), 1'b0});
            case (f[1:0])
                2'b00:   exp_strb = (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 :
                                    (off == 2'd2) ? 4'b0100 : 4'b1000;
                2'b01:   exp_strb = off[1] ? 4'b1100 : 4'b0011;
                default: exp_strb = 4'b1111;
            endcase
            exp_wdata = d << (8 * off);
            send(!st, st, f, a, st ? d : 32'd0);
            if (st) begin
                checks++;
                if (wdata !== exp_wdata || wstrb !== exp_strb || awaddr !== a) begin
                    errors++;
                    $display("FAIL b2b_store %0d got wdata=%h wstrb=%b awaddr=%h want %h/%b/%h",
                             i, wdata, wstrb, awaddr, exp_wdata, exp_strb, a);
                end
            end
            n = 0;
            while (rready !== 1'b1 && bready !== 1'b1 && n < 10) begin
                @(negedge clock);
                n++;
            end
            if (st) begin bvalid = 1'b1; bresp = 2'b00; end
            else    begin rvalid = 1'b1; rdata = d; rresp = 2'b00; end
            @(negedge clock);
            rvalid = 1'b0; bvalid = 1'b0;
            wait_out(n);
            e = exp_q.pop_front();
            checks++;
            if (n >= 50 || out_valid !== 1'b1 || {out_rdata, out_err} !== e) begin
                errors++;
                $display("FAIL b2b_resp %0d func=%b addr=%h got v=%b %h/%b want 1 %h/%b",
                         i, f, a, out_valid, out_rdata, out_err, e[32:1], e[0]);
            end
            @(negedge clock);
        end
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        arready = 1'b1;
        send(1'b1, 1'b0, 3'b010, 32'h80000020, 32'd0);
        @(negedge clock);
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got rready=%b want 1", rready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({arvalid, rready, out_valid, in_ready, awvalid, wvalid, bready} !== 7'b0001000 ||
            araddr !== 32'd0 || out_rdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid got ctrl=%b araddr=%h rdata=%h want 0001000/0/0",
                     {arvalid, rready, out_valid, in_ready, awvalid, wvalid, bready}, araddr, out_rdata);
        end
        @(negedge clock);
        reset = 1'b0;
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0 || rready !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_stray cycle %0d got v=%b rready=%b in_ready=%b want 0/0/1",
                         i, out_valid, rready, in_ready);
            end
        end
        rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu_delay();
        test_sb();
        test_misaligned();
        test_sw_err();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_read();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_23060203_lsu.md
# ysyx_23060203_lsu

Multi-cycle load/store unit placed directly downstream of the execute stage. It takes one memory request per handshake: read/write enable, funct3, effective address (ALU result) and store data (src2). It performs the access over an AXI4-Lite master port, then returns load data, already sign- or zero-extended, to the write-back path. This replaces the combinational memory read/write path with a bus-facing, latency-tolerant stage.

## Interface
- No parameters; data and address width are fixed at 32 bits, and bus width at 32 bits.
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid from the execute stage
- in_ready  out  1  LSU can accept a request; equals (state == IDLE)
- in_ren / in_wen  in  1 / 1  load / store request; if both are 1, the request is a store
- in_func  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_addr  in  32  effective byte address
- in_wdata  in  32  store data, right-aligned
- out_valid  out  1  response valid toward write-back
- out_ready  in  1  write-back accepts the response
- out_rdata  out  32  extended load data; 0 for stores and no-op requests
- out_err  out  1  misaligned access or non-OKAY bus response
- araddr, arvalid / arready  out 32, out 1 / in 1  read address channel
- rdata, rresp, rvalid / rready  in 32, in 2, in 1 / out 1  read data channel
- awaddr, awvalid / awready  out 32, out 1 / in 1  write address channel
- wdata, wstrb, wvalid / wready  out 32, out 4, out 1 / in 1  write data channel
- bresp, bvalid / bready  in 2, in 1 / out 1  write response channel

## Operation
- **States:** IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
- **Accept:** on in_valid & in_ready, latch the request (addr, func, lane-shifted data, strobe) and compute misalignment:
  - H/HU are misaligned when addr[0] = 1.
  - W is misaligned when addr[1:0] ≠ 0.
  - An undefined func is treated as W.
- **IDLE transitions** after accept:
  - misaligned → DONE with err = 1; no bus traffic is issued.
  - in_wen = 1 → WRITE.
  - in_ren = 1 → RADDR.
  - neither → DONE with err = 0 and rdata = 0.
- **RADDR:**
  - arvalid = 1; araddr = latched address, unmodified.
  - Move to RDATA on arready.
- **RDATA:**
  - rready = 1.
  - On rvalid, shift rdata right by 8 × addr[1:0], then extend: B/H sign-extend, BU/HU zero-extend, W pass through.
  - Register the result into out_rdata; err = (rresp ≠ 00). Go to DONE.
- **WRITE:**
  - awvalid and wvalid are asserted together.
  - Each channel drops independently after its own handshake; both may complete in the same cycle.
  - Go to WRESP once both channels are done.
  - wdata = in_wdata << 8 × addr[1:0].
  - wstrb: B = 0001 << off, H = 0011 << off, W = 1111.
- **WRESP:**
  - bready = 1.
  - On bvalid, err = (bresp ≠ 00); go to DONE.
- **DONE:**
  - out_valid = 1; out_rdata and out_err are held stable.
  - On out_ready, return to IDLE.
  - A new request cannot be accepted in the same cycle; in_ready rises the following cycle.
- **Bus-facing outputs:** all AXI valid/ready outputs are registered or decoded from state only, never combinationally from AXI inputs.
- **Reset:**
  - All outputs go to 0 immediately, except in_ready, which becomes 1 (IDLE).
  - A reset in mid-transaction abandons that transaction; the LSU ignores any later AXI response belonging to it.

## Timing
- **Valid stability:** once asserted, arvalid, awvalid and wvalid hold, with stable address, data and strobe, until their handshake.
- **Read latency, zero-wait bus:**
  - Accept in cycle T; arvalid in T+1 with arready in T+1.
  - rvalid in T+2; out_valid in T+3.
- **Write latency, zero-wait bus:**
  - Accept in T; awvalid/wvalid in T+1, both ready in T+1.
  - bvalid in T+2; out_valid in T+3.
- **Misaligned or no-op request:** out_valid in T+1.
- **Back-pressure:** out_valid holds with constant data for as long as out_ready = 0.

## Test plan
- **LB, sign-extend:** LB at 0x80000003, rdata 0x80123456, rresp 00 → out_rdata 0xFFFFFF80, err 0, out_valid at T+3.
- **LHU, delayed handshakes:** LHU at 0x80000002, rdata 0xBEEF1234, arready delayed 2 cycles → out_rdata 0x0000BEEF, arvalid/araddr held stable throughout.
- **SB, lane shift:** SB at 0x80000002, in_wdata 0x000000AB → wdata 0x00AB0000, wstrb 0100; awready 3 cycles late, wready immediate → wvalid drops after 1 cycle, awvalid after 4, bready only after both.
- **Misaligned and bus error:**
  - LW at 0x80000002 → no arvalid, out_err 1 at T+1.
  - SW with bresp 10 → out_err 1.
- **Back-pressure:** out_ready = 0 for 5 cycles → out_valid/out_rdata stable, in_ready 0; in_ready returns 1 the cycle after out_ready.
- **Reset mid-read:** reset asserted in RDATA → arvalid/rready/out_valid 0 immediately, in_ready 1; a later stray rvalid produces no out_valid.
